// File: rtl/decode_stage.sv
// ID stage of a 5-stage MIPS-style pipeline: decode, register file, hazard detection,
// early branch/jump resolution and the ID/EX pipeline register.
module decode_stage #(
  parameter int NB_BITS = 32,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_if_id_pc,
  input  logic [NB_BITS-1:0] i_if_id_instr,
  input  logic               i_wb_we,
  input  logic [NB_REG-1:0]  i_wb_addr,
  input  logic [NB_BITS-1:0] i_wb_data,
  input  logic               i_ex_mem_reg_write,
  input  logic [NB_REG-1:0]  i_ex_mem_wr_addr,
  output logic [NB_BITS-1:0] o_brq_addr,
  output logic [NB_BITS-1:0] o_jmp_addr,
  output logic               o_ctr_beq,
  output logic               o_ctr_jmp,
  output logic               o_ctr_flush,
  output logic               o_pc_we,
  output logic               o_if_id_we,
  output logic [NB_BITS-1:0] o_id_ex_pc,
  output logic [NB_BITS-1:0] o_id_ex_rs_data,
  output logic [NB_BITS-1:0] o_id_ex_rt_data,
  output logic [NB_BITS-1:0] o_id_ex_imm,
  output logic [NB_REG-1:0]  o_id_ex_rs,
  output logic [NB_REG-1:0]  o_id_ex_rt,
  output logic [NB_REG-1:0]  o_id_ex_rd,
  output logic [5:0]         o_id_ex_op,
  output logic [5:0]         o_id_ex_ctrl
);

  localparam int NREGS = 2 ** NB_REG;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_J    = 6'h02;

  // ctrl bits: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst
  localparam logic [5:0] CTRL_R    = 6'b100001;
  localparam logic [5:0] CTRL_ADDI = 6'b100010;
  localparam logic [5:0] CTRL_LW   = 6'b110110;
  localparam logic [5:0] CTRL_SW   = 6'b001010;

  function automatic logic signed [NB_BITS-1:0] sext16(input logic [15:0] v);
    sext16 = {{(NB_BITS-16){v[15]}}, v};
  endfunction

  logic [NB_BITS-1:0] rf [NREGS];

  logic [5:0]                op;
  logic [NB_REG-1:0]         rs, rt, rd;
  logic signed [NB_BITS-1:0] imm_ext;
  logic [5:0]                ctrl;
  logic                      is_beq, is_bne, is_j, uses_rt;
  logic [NB_BITS-1:0]        rs_data, rt_data;
  logic [NB_REG-1:0]         ex_dst;
  logic                      load_use, br_stall, stall, taken;

  logic [NB_BITS-1:0] id_ex_pc_p1, id_ex_rs_data_p1, id_ex_rt_data_p1, id_ex_imm_p1;
  logic [NB_REG-1:0]  id_ex_rs_p1, id_ex_rt_p1, id_ex_rd_p1;
  logic [5:0]         id_ex_op_p1, id_ex_ctrl_p1;

  assign op      = i_if_id_instr[31:26];
  assign rs      = i_if_id_instr[21 +: NB_REG];
  assign rt      = i_if_id_instr[16 +: NB_REG];
  assign rd      = i_if_id_instr[11 +: NB_REG];
  assign imm_ext = sext16(i_if_id_instr[15:0]);

  always_comb begin
    ctrl    = '0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_j    = 1'b0;
    uses_rt = 1'b0;
    case (op)
      OP_R:    begin ctrl = CTRL_R;  uses_rt = 1'b1; end
      OP_ADDI: ctrl = CTRL_ADDI;
      OP_LW:   ctrl = CTRL_LW;
      OP_SW:   begin ctrl = CTRL_SW; uses_rt = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1;  uses_rt = 1'b1; end
      OP_BNE:  begin is_bne = 1'b1;  uses_rt = 1'b1; end
      OP_J:    is_j = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Register reads forward the WB write of the same cycle
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != '0)
      rs_data = (i_wb_we && i_wb_addr == rs) ? i_wb_data : rf[rs];
    if (rt != '0)
      rt_data = (i_wb_we && i_wb_addr == rt) ? i_wb_data : rf[rt];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (i_wb_we && i_wb_addr != '0) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  assign ex_dst = id_ex_ctrl_p1[0] ? id_ex_rd_p1 : id_ex_rt_p1;

  // j carries target bits in the rs field, so it is excluded from load-use
  always_comb begin
    load_use = id_ex_ctrl_p1[4] && (id_ex_rt_p1 != '0) && !is_j &&
               ((id_ex_rt_p1 == rs) || (uses_rt && id_ex_rt_p1 == rt));
    br_stall = (is_beq || is_bne) && (
      ((rs != '0) && ((id_ex_ctrl_p1[5] && rs == ex_dst) ||
                      (i_ex_mem_reg_write && rs == i_ex_mem_wr_addr))) ||
      ((rt != '0) && ((id_ex_ctrl_p1[5] && rt == ex_dst) ||
                      (i_ex_mem_reg_write && rt == i_ex_mem_wr_addr))));
    stall    = !i_rst && (load_use || br_stall);
    taken    = (is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data);
  end

  always_comb begin
    o_jmp_addr       = i_if_id_pc;
    o_jmp_addr[27:0] = {i_if_id_instr[25:0], 2'b00};
  end

  assign o_brq_addr  = i_if_id_pc + $unsigned(imm_ext <<< 2);
  assign o_ctr_beq   = !i_rst && !stall && taken;
  assign o_ctr_jmp   = !i_rst && !stall && is_j;
  assign o_ctr_flush = o_ctr_beq || o_ctr_jmp;
  assign o_pc_we     = !stall;
  assign o_if_id_we  = !stall;

  // ID -> EX boundary; a stall loads an all-zero bubble
  always_ff @(posedge i_clk) begin
    if (i_rst || stall) begin
      id_ex_pc_p1      <= '0;
      id_ex_rs_data_p1 <= '0;
      id_ex_rt_data_p1 <= '0;
      id_ex_imm_p1     <= '0;
      id_ex_rs_p1      <= '0;
      id_ex_rt_p1      <= '0;
      id_ex_rd_p1      <= '0;
      id_ex_op_p1      <= '0;
      id_ex_ctrl_p1    <= '0;
    end else begin
      id_ex_pc_p1      <= i_if_id_pc;
      id_ex_rs_data_p1 <= rs_data;
      id_ex_rt_data_p1 <= rt_data;
      id_ex_imm_p1     <= $unsigned(imm_ext);
      id_ex_rs_p1      <= rs;
      id_ex_rt_p1      <= rt;
      id_ex_rd_p1      <= rd;
      id_ex_op_p1      <= op;
      id_ex_ctrl_p1    <= ctrl;
    end
  end

  assign o_id_ex_pc      = id_ex_pc_p1;
  assign o_id_ex_rs_data = id_ex_rs_data_p1;
  assign o_id_ex_rt_data = id_ex_rt_data_p1;
  assign o_id_ex_imm     = id_ex_imm_p1;
  assign o_id_ex_rs      = id_ex_rs_p1;
  assign o_id_ex_rt      = id_ex_rt_p1;
  assign o_id_ex_rd      = id_ex_rd_p1;
  assign o_id_ex_op      = id_ex_op_p1;
  assign o_id_ex_ctrl    = id_ex_ctrl_p1;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter NB_BITS, default 32, datapath width.
REQ-002 The block SHALL have parameter NB_REG, default 5, register-address width.
REQ-003 The block SHALL have these ports:
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_if_id_pc  in  NB_BITS  PC+4 of the instruction in IF/ID.
- i_if_id_instr  in  NB_BITS  instruction in IF/ID.
- i_wb_we  in  1  register-file write enable from WB.
- i_wb_addr  in  NB_REG  WB destination register.
- i_wb_data  in  NB_BITS  WB write data.
- i_ex_mem_reg_write  in  1  EX/MEM instruction writes a register.
- i_ex_mem_wr_addr  in  NB_REG  EX/MEM destination register.
- o_brq_addr  out  NB_BITS  branch target.
- o_jmp_addr  out  NB_BITS  jump target.
- o_ctr_beq  out  1  branch taken.
- o_ctr_jmp  out  1  jump taken.
- o_ctr_flush  out  1  squash IF/ID.
- o_pc_we  out  1  PC write enable.
- o_if_id_we  out  1  IF/ID write enable.
- o_id_ex_pc  out  NB_BITS  registered PC+4.
- o_id_ex_rs_data / o_id_ex_rt_data  out  NB_BITS  registered operands.
- o_id_ex_imm  out  NB_BITS  registered sign-extended imm[15:0].
- o_id_ex_rs / o_id_ex_rt / o_id_ex_rd  out  NB_REG  registered register fields.
- o_id_ex_op  out  6  registered opcode.
- o_id_ex_ctrl  out  6  registered control: [5] reg_write, [4] mem_read, [3] mem_write, [2] mem_to_reg, [1] alu_src, [0] reg_dst.

Function
REQ-004 The block SHALL decode R-type (op 0x00), addi (0x08), lw (0x23), sw (0x2B), beq (0x04), bne (0x05), and j (0x02).
REQ-005 Control encoding SHALL be R=100001, addi=100010, lw=110110, sw=001010, and beq/bne/j/any other opcode=000000; an all-zero instruction is a NOP.
REQ-006 The register file SHALL be 32 x NB_BITS, with register 0 reading 0 and ignoring writes.
REQ-007 A register write SHALL occur on the rising edge when i_wb_we=1 and i_wb_addr!=0.
REQ-008 Register reads SHALL be combinational with write-through: if i_wb_we=1 and i_wb_addr equals a nonzero read address, the read returns i_wb_data.
REQ-009 Target arithmetic SHALL be modulo 2^NB_BITS:
- o_brq_addr = i_if_id_pc + (sext(imm16) << 2).
- o_jmp_addr = {i_if_id_pc[31:28], instr[25:0], 2'b00}.
REQ-010 Load-use stall SHALL assert when ID/EX ctrl[4]=1, ID/EX rt!=0, and ID/EX rt equals the decoding instruction's rs, or its rt when it is R, beq, bne, or sw.
REQ-011 Branch stall SHALL assert when the instruction is beq/bne and a nonzero rs or rt matches either:
- the ID/EX destination (rd if ctrl[0], else rt) with ctrl[5]=1; or
- i_ex_mem_wr_addr with i_ex_mem_reg_write=1.
REQ-012 While stalled, o_pc_we=0, o_if_id_we=0, o_ctr_beq=0, o_ctr_jmp=0 and o_ctr_flush=0, and the next ID/EX load SHALL be an all-zero bubble.
REQ-013 When not stalled, o_pc_we=1 and o_if_id_we=1, and ID/EX SHALL capture the decoded fields with one-cycle latency.
REQ-014 A branch SHALL be taken when beq has equal operands or bne has unequal operands; a taken branch sets o_ctr_beq=1 and o_ctr_flush=1.
REQ-015 j SHALL set o_ctr_jmp=1 and o_ctr_flush=1; j never stalls.
REQ-016 o_ctr_beq, o_ctr_jmp, o_ctr_flush, o_pc_we and o_if_id_we SHALL be combinational from IF/ID and ID/EX state.
REQ-017 Stall SHALL have priority over branch, jump and flush in the same cycle.
REQ-018 A branch stalled for N cycles SHALL re-evaluate each cycle and resolve on the first non-stalled cycle.

Reset
REQ-019 On a rising edge with i_rst=1, all registers, the register file and all ID/EX outputs SHALL become 0.
REQ-020 While i_rst=1, o_ctr_beq, o_ctr_jmp and o_ctr_flush SHALL be 0, and o_pc_we and o_if_id_we SHALL be 1.
REQ-021 Reset asserted mid-stall SHALL cancel the stall; the first post-reset cycle SHALL decode the IF/ID contents with no stall pending.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- WB writes r5=0x1234 while IF/ID holds add r1,r5,r0 -> next cycle o_id_ex_rs_data=0x1234 (write-through).
- lw r2,0(r1) in ID/EX, IF/ID add r3,r2,r4 -> one cycle with o_pc_we=0, o_if_id_we=0, then o_id_ex_ctrl=000000; next cycle add decodes, ctrl=100001.
- beq r1,r1,+3 at PC+4=0x10 with no hazard -> o_ctr_beq=1, o_ctr_flush=1, o_brq_addr=0x1C.
- bne r1,r2,-1 at PC+4=0x20, with ID/EX addi r2 and then EX/MEM r2 -> two stall cycles, then taken with o_brq_addr=0x1C.
- j 0x0000040 at PC+4=0x40000008 -> o_ctr_jmp=1, o_jmp_addr=0x40000100.
- Write to r0 with data 0xFFFF, then read r0 -> 0; assert i_rst mid-stall -> all ID/EX outputs 0 and o_pc_we=1.
